// File: rtl/sample_capture_writer_if.sv
// sample_capture_writer_if: the writer's control, ADC stream, RAM write port
// and status signals in one bundle.
// The slave modport is the writer; the master modport is its environment
// (front end, consumer and the RAM write side).
// The buffer-release pulse is named buf_release because "release" is a
// reserved word in SystemVerilog.
interface sample_capture_writer_if #(
  parameter int INPUT_WIDTH = 12,
  parameter int ADDR_WIDTH  = 15
);

  // Capture control and consumer handshake
  logic                   capture_start;
  logic                   buf_release;
  logic                   epoch_tick;

  // ADC I/Q sample stream
  logic                   adc_valid;
  logic [INPUT_WIDTH-1:0] adc_i;
  logic [INPUT_WIDTH-1:0] adc_q;

  // Sample RAM write port
  logic                   wr_en;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [INPUT_WIDTH-1:0] wr_x;
  logic [INPUT_WIDTH-1:0] wr_y;

  // Status
  logic                   busy;
  logic                   capture_done;
  logic [7:0]             ms_count;
  logic                   overrun;
  logic [15:0]            dropped;

  modport slave (
    input  capture_start, buf_release, epoch_tick,
    input  adc_valid, adc_i, adc_q,
    output wr_en, wr_addr, wr_x, wr_y,
    output busy, capture_done, ms_count, overrun, dropped
  );

  modport master (
    output capture_start, buf_release, epoch_tick,
    output adc_valid, adc_i, adc_q,
    input  wr_en, wr_addr, wr_x, wr_y,
    input  busy, capture_done, ms_count, overrun, dropped
  );

endinterface

// File: rtl/sample_capture_writer.sv
// sample_capture_writer: writes one contiguous block of CAPTURE_MS ms of ADC
// I/Q samples into the sample RAM, then holds the block (capture_done) until
// the consumer releases it.
// Optional feature macro: CAPTURE_EPOCH_ALIGN_EN. When it is defined, ARM
// waits for epoch_tick, and the sample that arrives with the tick lands at
// address 0. This makes RAM millisecond boundaries coincide with front-end
// epochs.
module sample_capture_writer #(
  parameter int INPUT_WIDTH    = 12,
  parameter int ADDR_WIDTH     = 15,
  parameter int SAMPLES_PER_MS = 2000,
  parameter int CAPTURE_MS     = 10
) (
  input logic                     clk,
  input logic                     reset,
  sample_capture_writer_if.slave  bus
);

  localparam int DEPTH = SAMPLES_PER_MS * CAPTURE_MS;
  localparam int MS_W  = (SAMPLES_PER_MS > 1) ? $clog2(SAMPLES_PER_MS) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [MS_W-1:0]       MS_LAST  = MS_W'(SAMPLES_PER_MS - 1);

  // The block must fit in the RAM without wrapping
  if (DEPTH > (2 ** ADDR_WIDTH)) begin : g_depth_check
    $error("sample_capture_writer: DEPTH (%0d) exceeds 2**ADDR_WIDTH", DEPTH);
  end

  if ($bits(bus.wr_addr) != ADDR_WIDTH || $bits(bus.wr_x) != INPUT_WIDTH) begin : g_width_check
    $error("sample_capture_writer: interface widths do not match module parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    FULL
  } state_t;

  state_t state;

  logic [ADDR_WIDTH-1:0]  write_idx;
  logic [MS_W-1:0]        ms_sample_cnt;

  logic                   wr_en_r;
  logic [ADDR_WIDTH-1:0]  wr_addr_r;
  logic [INPUT_WIDTH-1:0] wr_x_r;
  logic [INPUT_WIDTH-1:0] wr_y_r;
  logic                   busy_r;
  logic                   capture_done_r;
  logic [7:0]             ms_count_r;
  logic                   overrun_r;
  logic [15:0]            dropped_r;

  logic                   accept;
  logic [ADDR_WIDTH-1:0]  idx_cur;
  logic [MS_W-1:0]        ms_cnt_cur;
  logic [7:0]             ms_count_cur;

`ifndef CAPTURE_EPOCH_ALIGN_EN
  logic epoch_tick_unused;
  assign epoch_tick_unused = bus.epoch_tick;
`endif

  // Decide whether this cycle's sample is written; an ARM-cycle acceptance starts from a fresh block
  always_comb begin
    idx_cur      = write_idx;
    ms_cnt_cur   = ms_sample_cnt;
    ms_count_cur = ms_count_r;
    if (state == ARM) begin
      idx_cur      = '0;
      ms_cnt_cur   = '0;
      ms_count_cur = '0;
    end
`ifdef CAPTURE_EPOCH_ALIGN_EN
    accept = bus.adc_valid &&
             ((state == CAPTURE) || ((state == ARM) && bus.epoch_tick));
`else
    accept = bus.adc_valid && (state == CAPTURE);
`endif
  end

  // Capture FSM with registered RAM-port and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      write_idx      <= '0;
      ms_sample_cnt  <= '0;
      wr_en_r        <= 1'b0;
      wr_addr_r      <= '0;
      wr_x_r         <= '0;
      wr_y_r         <= '0;
      busy_r         <= 1'b0;
      capture_done_r <= 1'b0;
      ms_count_r     <= '0;
      overrun_r      <= 1'b0;
      dropped_r      <= '0;
    end else begin
      wr_en_r <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.capture_start) begin
            state  <= ARM;
            busy_r <= 1'b1;
          end
        end

        ARM: begin
          write_idx     <= '0;
          ms_sample_cnt <= '0;
          wr_addr_r     <= '0;
          ms_count_r    <= '0;
          overrun_r     <= 1'b0;
          dropped_r     <= '0;
`ifdef CAPTURE_EPOCH_ALIGN_EN
          if (bus.epoch_tick) begin
            state <= CAPTURE;
          end
`else
          state <= CAPTURE;
`endif
        end

        CAPTURE: begin
        end

        FULL: begin
          if (bus.adc_valid) begin
            overrun_r <= 1'b1;
            if (dropped_r != 16'hFFFF) begin
              dropped_r <= dropped_r + 16'd1;
            end
          end
          if (bus.buf_release && bus.capture_start) begin
            state          <= ARM;
            capture_done_r <= 1'b0;
            busy_r         <= 1'b1;
          end else if (bus.buf_release) begin
            state          <= IDLE;
            capture_done_r <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase

      if (accept) begin
        wr_en_r   <= 1'b1;
        wr_addr_r <= idx_cur;
        wr_x_r    <= bus.adc_i;
        wr_y_r    <= bus.adc_q;

        if (idx_cur == LAST_IDX) begin
          write_idx      <= idx_cur;
          capture_done_r <= 1'b1;
          busy_r         <= 1'b0;
          state          <= FULL;
        end else begin
          write_idx <= idx_cur + 1'b1;
        end

        if (ms_cnt_cur == MS_LAST) begin
          ms_sample_cnt <= '0;
          ms_count_r    <= ms_count_cur + 8'd1;
        end else begin
          ms_sample_cnt <= ms_cnt_cur + 1'b1;
          ms_count_r    <= ms_count_cur;
        end
      end
    end
  end

  assign bus.wr_en        = wr_en_r;
  assign bus.wr_addr      = wr_addr_r;
  assign bus.wr_x         = wr_x_r;
  assign bus.wr_y         = wr_y_r;
  assign bus.busy         = busy_r;
  assign bus.capture_done = capture_done_r;
  assign bus.ms_count     = ms_count_r;
  assign bus.overrun      = overrun_r;
  assign bus.dropped      = dropped_r;

endmodule

// File: tb/tb_sample_capture_writer.sv
// tb_sample_capture_writer: scoreboard bench for sample_capture_writer with
// SAMPLES_PER_MS=4, CAPTURE_MS=2 (an 8-sample block).
// Expected writes are queued when a sample is driven that should be accepted.
// They are checked when wr_en appears.
// Build with CAPTURE_EPOCH_ALIGN_EN defined to also exercise epoch alignment.
module tb_sample_capture_writer;

  localparam int IW    = 12;
  localparam int AW    = 15;
  localparam int SPM   = 4;
  localparam int CMS   = 2;
  localparam int DEPTH = SPM * CMS;

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] x;
    logic [IW-1:0] y;
    logic [7:0]    ms;
    logic          last;
  } exp_t;

  logic clk;
  logic reset;

  exp_t exp_q[$];
  int   model_idx;
  int   n_checks;
  int   n_fail;

  sample_capture_writer_if #(.INPUT_WIDTH(IW), .ADDR_WIDTH(AW)) ifc ();

  sample_capture_writer #(
    .INPUT_WIDTH   (IW),
    .ADDR_WIDTH    (AW),
    .SAMPLES_PER_MS(SPM),
    .CAPTURE_MS    (CMS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of ADC input; queue the write it should cause, if any
  task automatic applyStimulus(input logic valid, input int n, input bit expect_write);
    int   neg;
    exp_t e;
    neg = -n;
    ifc.adc_valid = valid;
    ifc.adc_i     = n[IW-1:0];
    ifc.adc_q     = neg[IW-1:0];
    if (expect_write) begin
      e.addr = model_idx[AW-1:0];
      e.x    = n[IW-1:0];
      e.y    = neg[IW-1:0];
      e.ms   = 8'((model_idx + 1) / SPM);
      e.last = (model_idx == DEPTH - 1);
      exp_q.push_back(e);
      model_idx++;
    end
    @(negedge clk);
    ifc.adc_valid = 1'b0;
  endtask

  // Start a capture (optionally releasing in the same cycle) and step through ARM
  task automatic startCapture(input bit with_release);
    ifc.capture_start = 1'b1;
    ifc.buf_release   = with_release;
    @(negedge clk);
    ifc.capture_start = 1'b0;
    ifc.buf_release   = 1'b0;
    checkOutput("arm_busy", 32'(ifc.busy), 32'd1);
    checkOutput("arm_done", 32'(ifc.capture_done), 32'd0);
`ifdef CAPTURE_EPOCH_ALIGN_EN
    ifc.epoch_tick = 1'b1;
`endif
    @(negedge clk);
    ifc.epoch_tick = 1'b0;
    checkOutput("cap_overrun", 32'(ifc.overrun), 32'd0);
    checkOutput("cap_dropped", 32'(ifc.dropped), 32'd0);
    checkOutput("cap_ms_count", 32'(ifc.ms_count), 32'd0);
    checkOutput("cap_busy", 32'(ifc.busy), 32'd1);
    model_idx = 0;
  endtask

  task automatic checkResetValues(input string phase);
    checkOutput({phase, "_wr_en"}, 32'(ifc.wr_en), 32'd0);
    checkOutput({phase, "_wr_addr"}, 32'(ifc.wr_addr), 32'd0);
    checkOutput({phase, "_wr_x"}, 32'(ifc.wr_x), 32'd0);
    checkOutput({phase, "_wr_y"}, 32'(ifc.wr_y), 32'd0);
    checkOutput({phase, "_busy"}, 32'(ifc.busy), 32'd0);
    checkOutput({phase, "_done"}, 32'(ifc.capture_done), 32'd0);
    checkOutput({phase, "_ms_count"}, 32'(ifc.ms_count), 32'd0);
    checkOutput({phase, "_overrun"}, 32'(ifc.overrun), 32'd0);
    checkOutput({phase, "_dropped"}, 32'(ifc.dropped), 32'd0);
  endtask

  // Scoreboard: every observed write must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (ifc.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_wr", 32'(ifc.wr_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(ifc.wr_addr), 32'(e.addr));
        checkOutput("wr_x", 32'(ifc.wr_x), 32'(e.x));
        checkOutput("wr_y", 32'(ifc.wr_y), 32'(e.y));
        checkOutput("wr_ms_count", 32'(ifc.ms_count), 32'(e.ms));
        checkOutput("wr_done", 32'(ifc.capture_done), 32'(e.last));
        checkOutput("wr_busy", 32'(ifc.busy), 32'(!e.last));
      end
    end
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    n_checks          = 0;
    n_fail            = 0;
    model_idx         = 0;
    reset             = 1'b1;
    ifc.capture_start = 1'b0;
    ifc.buf_release   = 1'b0;
    ifc.epoch_tick    = 1'b0;
    ifc.adc_valid     = 1'b0;
    ifc.adc_i         = '0;
    ifc.adc_q         = '0;
    repeat (2) @(negedge clk);
    checkResetValues("rst");
    reset = 1'b0;

    // Back-to-back block of 8 samples
    $display("[TB] back-to-back capture");
    startCapture(1'b0);
    for (int n = 0; n < DEPTH; n++) applyStimulus(1'b1, n, 1'b1);
    checkOutput("full_ms_count", 32'(ifc.ms_count), 32'd2);
    checkOutput("full_busy", 32'(ifc.busy), 32'd0);

    // Samples while FULL are dropped
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 100 + k, 1'b0);
    checkOutput("full_wr_en", 32'(ifc.wr_en), 32'd0);
    checkOutput("full_overrun", 32'(ifc.overrun), 32'd1);
    checkOutput("full_dropped", 32'(ifc.dropped), 32'd3);
    checkOutput("full_addr_hold", 32'(ifc.wr_addr), 32'(DEPTH - 1));

    // capture_start alone in FULL is ignored
    ifc.capture_start = 1'b1;
    @(negedge clk);
    ifc.capture_start = 1'b0;
    checkOutput("start_ign_done", 32'(ifc.capture_done), 32'd1);
    checkOutput("start_ign_busy", 32'(ifc.busy), 32'd0);
    applyStimulus(1'b1, 50, 1'b0);
    checkOutput("start_ign_dropped", 32'(ifc.dropped), 32'd4);

    // Release returns to IDLE
    ifc.buf_release = 1'b1;
    @(negedge clk);
    ifc.buf_release = 1'b0;
    checkOutput("rel_done", 32'(ifc.capture_done), 32'd0);
    checkOutput("rel_busy", 32'(ifc.busy), 32'd0);
    applyStimulus(1'b1, 77, 1'b0);
    checkOutput("idle_wr_en", 32'(ifc.wr_en), 32'd0);

    // Gapped stream: one sample every third cycle
    $display("[TB] gapped capture");
    startCapture(1'b0);
    for (int n = 0; n < DEPTH; n++) begin
      applyStimulus(1'b1, 20 + n, 1'b1);
      if (n < DEPTH - 1) begin
        applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);
      end
    end
    checkOutput("gap_done", 32'(ifc.capture_done), 32'd1);
    checkOutput("gap_ms_count", 32'(ifc.ms_count), 32'd2);
    ifc.buf_release = 1'b1;
    @(negedge clk);
    ifc.buf_release = 1'b0;

    // Reset in the middle of a capture, after the write at address 5
    $display("[TB] reset mid-capture");
    startCapture(1'b0);
    for (int n = 0; n < 6; n++) applyStimulus(1'b1, n + 1, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    checkResetValues("midrst");
    reset = 1'b0;
    startCapture(1'b0);
    for (int n = 0; n < DEPTH; n++) applyStimulus(1'b1, 30 + n, 1'b1);
    checkOutput("rewrite_done", 32'(ifc.capture_done), 32'd1);

    // Release and start together in FULL: immediate recapture
    $display("[TB] release+start recapture");
    applyStimulus(1'b1, 90, 1'b0);
    applyStimulus(1'b1, 91, 1'b0);
    checkOutput("pre_recap_overrun", 32'(ifc.overrun), 32'd1);
    checkOutput("pre_recap_dropped", 32'(ifc.dropped), 32'd2);
    startCapture(1'b1);
    for (int n = 0; n < DEPTH; n++) applyStimulus(1'b1, 40 + n, 1'b1);
    checkOutput("recap_done", 32'(ifc.capture_done), 32'd1);
    checkOutput("recap_dropped", 32'(ifc.dropped), 32'd0);

`ifdef CAPTURE_EPOCH_ALIGN_EN
    // Epoch alignment: pre-tick samples are discarded silently
    $display("[TB] epoch-aligned capture");
    ifc.buf_release = 1'b1;
    @(negedge clk);
    ifc.buf_release   = 1'b0;
    ifc.capture_start = 1'b1;
    @(negedge clk);
    ifc.capture_start = 1'b0;
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 60 + k, 1'b0);
    checkOutput("epoch_wait_busy", 32'(ifc.busy), 32'd1);
    checkOutput("epoch_wait_dropped", 32'(ifc.dropped), 32'd0);
    model_idx = 0;
    ifc.epoch_tick = 1'b1;
    applyStimulus(1'b1, 9, 1'b1);
    ifc.epoch_tick = 1'b0;
    checkOutput("epoch_dropped", 32'(ifc.dropped), 32'd0);
    checkOutput("epoch_overrun", 32'(ifc.overrun), 32'd0);
    applyStimulus(1'b1, 10, 1'b1);
`endif

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_capture_writer.md
Name: sample_capture_writer

Overview:
- Writer end of the acquisition sample memory.
- Takes the ADC I/Q stream and writes one contiguous block of CAPTURE_MS milliseconds into the sample RAM that the acquisition engine reads.
- Handshakes with the consumer: raises capture_done when the block is complete, then holds the buffer until the consumer releases it.
- Sits between the front-end ADC interface and the sample RAM's write port, alongside the acquisition and tracking read ports.

Parameters:
INPUT_WIDTH, 12, width of each I and Q sample.
ADDR_WIDTH, 15, RAM write-address width.
SAMPLES_PER_MS, 2000, samples per millisecond (sampling frequency in kHz).
CAPTURE_MS, 10, milliseconds per capture; DEPTH = SAMPLES_PER_MS*CAPTURE_MS, and DEPTH must be ≤ 2^ADDR_WIDTH (elaboration-time check, $error).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
capture_start  input  1  single-cycle request to begin a capture
release  input  1  single-cycle pulse from the consumer: buffer no longer needed
epoch_tick  input  1  1 ms epoch strobe from the front end (used only with the optional feature)
adc_valid  input  1  sample qualifier
adc_i  input  INPUT_WIDTH  in-phase sample
adc_q  input  INPUT_WIDTH  quadrature sample
wr_en  output  1  RAM write strobe
wr_addr  output  ADDR_WIDTH  RAM write address
wr_x  output  INPUT_WIDTH  I data to RAM
wr_y  output  INPUT_WIDTH  Q data to RAM
busy  output  1  high in ARM or CAPTURE
capture_done  output  1  high in FULL
ms_count  output  8  completed milliseconds in the current capture
overrun  output  1  sticky: a sample arrived while in FULL
dropped  output  16  count of samples arriving while in FULL, saturating

Behaviour:
- All outputs are registered.
- Reset values: wr_en=0, wr_addr=0, wr_x=0, wr_y=0, busy=0, capture_done=0, ms_count=0, overrun=0, dropped=0; state=IDLE.
- Reset has priority over every other input and aborts any capture mid-operation.
- States:
  - IDLE: capture_start → ARM.
  - ARM: clear wr_addr, ms_count, overrun and dropped; next cycle → CAPTURE.
  - CAPTURE: each adc_valid produces one write on the next cycle: wr_en=1, wr_x/wr_y = the sample, wr_addr = the write index.
    - The write index starts at 0 and increments by 1 after each write.
    - A per-ms sample counter wraps at SAMPLES_PER_MS-1; each wrap increments ms_count.
    - The write at index DEPTH-1 is the last one: in that same cycle capture_done rises and state → FULL.
    - wr_addr then holds DEPTH-1.
  - FULL: wr_en=0. Every adc_valid sets overrun and increments dropped, saturating at 16'hFFFF. release → IDLE, clearing capture_done.
- wr_en is high for exactly one cycle per accepted sample. Latency from adc_valid to wr_en is 1 cycle.
- Back-to-back adc_valid sustains 1 write per clock.
- capture_start in ARM or CAPTURE: ignored.
- release outside FULL: ignored.
- release and capture_start in the same cycle while in FULL: → ARM (immediate recapture); capture_done falls.
- capture_start alone in FULL: ignored; the buffer is protected until released.
- wr_addr never exceeds DEPTH-1, and there is no wrap-around inside a capture.

Optional Feature:
- Macro: CAPTURE_EPOCH_ALIGN_EN.
- Defined:
  - ARM waits for epoch_tick before entering CAPTURE.
  - The sample qualified in the same cycle as epoch_tick is written to address 0.
  - Samples before the tick are discarded and are not counted in dropped.
  - busy stays high while waiting.
  - So ms boundaries in RAM coincide with front-end epochs.
- Undefined: epoch_tick is ignored; ARM lasts one cycle as described above.

Test Plan:
- Bench parameters: SAMPLES_PER_MS=4, CAPTURE_MS=2 (DEPTH=8).
- Reset then start; adc_valid held high with adc_i=n, adc_q=-n for n=0..7 → eight wr_en pulses with wr_addr 0..7 and matching data; capture_done rises with the addr-7 write; ms_count=2; busy=0.
- While FULL, send 3 more samples → wr_en stays 0, overrun=1, dropped=3; capture_start alone is ignored; then release → IDLE, capture_done=0.
- Gapped stream (adc_valid every 3rd cycle) → addresses still 0..7 contiguous; ms_count increments after the 4th and 8th writes only.
- Assert reset after the write at wr_addr=5 → all outputs return to reset values next cycle; a new start rewrites from addr 0.
- release and capture_start in the same cycle in FULL → ARM, then CAPTURE; a new 8-sample block is written from addr 0 and overrun/dropped are cleared.
- With CAPTURE_EPOCH_ALIGN_EN: start, then 5 valid samples, then epoch_tick together with sample value 9 → first write is addr 0 with wr_x=9; the 5 pre-tick samples produce no writes and dropped=0.
